// File: rtl/unsigned_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package unsigned_multiplier_pkg;

    typedef enum logic {StIdle, StCalc} state_e;

    localparam int unsigned WIDTH_DEFAULT = 4;

    // Counter must be able to hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/umul_shift_add_dp.sv
// Shift-add datapath: multiplicand/multiplier shift registers and accumulator.
module umul_shift_add_dp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   x_i,
    input  logic [WIDTH-1:0]   y_i,
    output logic [2*WIDTH-1:0] acc_next_o
);

    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step;

    // Accumulator value including the current step's conditional add.
    assign acc_step   = b_q[0] ? (acc_q + a_q) : acc_q;
    assign acc_next_o = acc_step;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (load_i) begin
            a_d   = {{WIDTH{1'b0}}, x_i};
            b_d   = y_i;
            acc_d = '0;
        end else if (step_i) begin
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            acc_d = acc_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/unsigned_multiplier_seq.sv
// Sequential unsigned multiplier: control FSM, step counter and product register.
// Optional UNSIGNED_MULTIPLIER_DONE_EN adds a one-cycle done pulse after each product write.
module unsigned_multiplier_seq
    import unsigned_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] p
`ifdef UNSIGNED_MULTIPLIER_DONE_EN
    ,
    output logic               done
`endif
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;
    logic               load, step;
    logic [2*WIDTH-1:0] acc_next;

    umul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .step_i     (step),
        .x_i        (x),
        .y_i        (y),
        .acc_next_o (acc_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (!en) begin
                    // Abort: drop the partial result, p is left untouched.
                    state_d = StIdle;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        p_d     = acc_next;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign p = p_q;

`ifdef UNSIGNED_MULTIPLIER_DONE_EN
    assign done = done_q;
`else
    logic unused_done;
    assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_unsigned_multiplier_seq.sv
// Self-checking bench for unsigned_multiplier_seq (WIDTH=4), with a transaction-level reference.
module tb_unsigned_multiplier_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           en = 1'b0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic [2*W-1:0] p;
`ifdef UNSIGNED_MULTIPLIER_DONE_EN
    logic           done;
`endif

    int checks = 0;
    int failures = 0;

    unsigned_multiplier_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .x     (x),
        .y     (y),
        .p     (p)
`ifdef UNSIGNED_MULTIPLIER_DONE_EN
        ,
        .done  (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an operation is W enabled clock edges after the capture edge; its result
    // is the arithmetic product of the captured operands.
    int             ref_steps = -1;
    int unsigned    ref_x, ref_y;
    logic [2*W-1:0] exp_p = '0;
    logic           exp_done = 1'b0;
    int             completions = 0;
    int             done_seen = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_steps = -1;
            exp_p     = '0;
            exp_done  = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (ref_steps < 0) begin
                if (en) begin
                    ref_x     = x;
                    ref_y     = y;
                    ref_steps = 0;
                end
            end else if (!en) begin
                ref_steps = -1;
            end else begin
                ref_steps++;
                if (ref_steps == W) begin
                    exp_p     = (2*W)'(ref_x * ref_y);
                    exp_done  = 1'b1;
                    completions++;
                    ref_steps = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("p_cycle", {8'h0, p}, {8'h0, exp_p});
`ifdef UNSIGNED_MULTIPLIER_DONE_EN
        check("done_cycle", {15'h0, done}, {15'h0, exp_done});
        if (done === 1'b1) done_seen++;
`endif
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for_p(input string name, input logic [2*W-1:0] want, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (p === want) seen = 1'b1;
        end
        check(name, {8'h0, p}, {8'h0, want});
    endtask

    initial begin
        #2 rst_n = 1'b0;
        cycles(3);
        check("reset_p", {8'h0, p}, 16'd0);
        rst_n = 1'b1;
        cycles(10);
        check("idle_p", {8'h0, p}, 16'd0);

        // 13*11: product lands on the 4th edge after the load edge, not earlier.
        x = 4'd13; y = 4'd11; en = 1'b1;
        cycles(4);
        check("no_early_p", {8'h0, p}, 16'd0);
        cycles(1);
        check("p_13x11", {8'h0, p}, 16'h008F);
        cycles(10);
        check("p_13x11_hold", {8'h0, p}, 16'd143);

        x = 4'd3; y = 4'd5;
        wait_for_p("p_3x5", 8'd15, 10);
        x = 4'd15; y = 4'd15;
        wait_for_p("p_15x15", 8'd225, 12);
        x = 4'd0; y = 4'd9;
        wait_for_p("p_0x9", 8'd0, 12);
        x = 4'd7; y = 4'd7;
        wait_for_p("p_7x7", 8'd49, 12);
        x = 4'd9; y = 4'd0;
        wait_for_p("p_9x0", 8'd0, 12);

        // Operand change mid-operation only affects the following operation.
        en = 1'b0;
        cycles(2);
        x = 4'd6; y = 4'd7; en = 1'b1;
        cycles(2);
        x = 4'd2; y = 4'd3;
        cycles(3);
        check("p_old_operands", {8'h0, p}, 16'd42);
        cycles(5);
        check("p_new_operands", {8'h0, p}, 16'd6);

        // Abort mid-operation keeps the previous product.
        en = 1'b0;
        cycles(2);
        x = 4'd5; y = 4'd5; en = 1'b1;
        cycles(2);
        en = 1'b0;
        cycles(6);
        check("p_after_abort", {8'h0, p}, 16'd6);

        // Asynchronous reset mid-operation.
        x = 4'd10; y = 4'd10; en = 1'b1;
        cycles(2);
        #3 rst_n = 1'b0;
        #1 check("p_async_reset", {8'h0, p}, 16'd0);
        en = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        check("p_after_reset", {8'h0, p}, 16'd0);

`ifdef UNSIGNED_MULTIPLIER_DONE_EN
        check("done_count", 16'(done_seen), 16'(completions));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
